kernel_control_multi_cu: RTL
============================

KERNEL_CONTROL_MULTI_CU -- requirements
Module: kernel_control_multi_cu

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of compute-unit channels, range 1..16.
REQ-002 SHALL have parameter RUN_COUNT_W, default 32: width of the completed-run counter.
REQ-003 SHALL have parameter WDOG_W, default 24: width of the watchdog counter (used only under KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 ap_clk  in  1: sole clock; all state updates on its rising edge.
REQ-006 areset  in  1: synchronous active-high reset.
REQ-007 ap_start  in  1: host start request, level.
REQ-008 channel_enable  in  NUM_CHANNELS: per-channel participation mask, latched when the block enters READY.
REQ-009 cu_setup  in  NUM_CHANNELS: per-channel setup-complete level.
REQ-010 cu_done  in  NUM_CHANNELS: per-channel done, a pulse or a level.
REQ-011 endian_cfg  in  1: endianness selection, sampled in START.
REQ-012 ap_ready, ap_done, ap_idle  out  1 each: host handshake outputs.
REQ-013 cu_start  out  NUM_CHANNELS: per-channel start, equal to the latched mask while active.
REQ-014 endian  out  1: endianness forwarded to the channels.
REQ-015 descriptor_valid  out  1: descriptor valid to the channels.
REQ-016 run_count  out  RUN_COUNT_W: number of completed runs.
REQ-017 timeout  out  1: watchdog flag, sticky; present only with the macro.

Function
REQ-018 SHALL register every input once before use and every output once; ap_start to ap_ready latency is exactly 3 cycles when all enabled cu_setup bits are already high.
REQ-019 SHALL implement the states RESET, IDLE, SETUP, READY, START, BUSY and DONE.
REQ-020 State transitions SHALL be: RESET->IDLE; IDLE->SETUP; SETUP->READY on ap_start; READY->START when every enabled channel's cu_setup is high; START->BUSY; BUSY->DONE when all enabled channels are done; DONE->READY on ap_start, otherwise DONE holds.
REQ-021 Per-state outputs SHALL be: RESET/IDLE drive idle=1 and all others 0; SETUP drives idle=1 and cu_start=mask; READY drives ready=1, idle=0 and cu_start=mask; START/BUSY drive descriptor_valid=1, cu_start=mask and endian=latched endian_cfg; DONE drives done=1, idle=1, cu_start=0 and descriptor_valid=0.
REQ-022 Done tracking SHALL use one sticky bit per channel: cleared on entry to START, set by cu_done only while in BUSY; cu_done asserted outside BUSY SHALL be ignored.
REQ-023 BUSY->DONE SHALL occur when (sticky | ~mask) is all ones; channels finishing in different cycles SHALL complete correctly.
REQ-024 An all-zero latched mask SHALL pass READY immediately and go BUSY->DONE on the first BUSY cycle.
REQ-025 run_count SHALL increment by 1 on each BUSY->DONE transition and SHALL wrap modulo 2^RUN_COUNT_W.
REQ-026 channel_enable changes after the block enters READY SHALL NOT affect the current run.

Reset
REQ-027 While areset is high: state=RESET, ap_idle=1, every other output 0, run_count=0, sticky bits 0, timeout=0.
REQ-028 Reset asserted mid-run SHALL abort within 1 cycle of registered reset and deassert cu_start and descriptor_valid.

Configuration
REQ-029 With KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle; on reaching 2^WDOG_W-1 the block SHALL set timeout and force BUSY->DONE without incrementing run_count; timeout SHALL clear on the next DONE->READY transition.
REQ-030 Without KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN: no counter and no timeout port SHALL exist, and BUSY SHALL wait indefinitely.

Structure
REQ-031 The state enumeration control_sync_state_multi_cu SHALL live in PKG_CONTROL, together with the defaults for NUM_CHANNELS, RUN_COUNT_W and WDOG_W.
REQ-032 The per-channel sticky-done tracker SHALL be a sub-module named kernel_control_done_tracker, with inputs clear, capture, cu_done and mask and output all_done.

Verification
REQ-033 Scenario: NUM_CHANNELS=4, mask=4'b1111, setup all high, ap_start pulse. Required: ap_ready at cycle 3, then descriptor_valid=1 and cu_start=4'hF.
REQ-034 Scenario: done pulses on channels 0,2,1,3 at BUSY cycles 5,9,12,20. Required: ap_done only after cycle 20 and run_count=1.
REQ-035 Scenario: mask=4'b0101 with cu_done only on channels 0 and 2. Required: DONE reached; cu_done[1] pulsing earlier in SETUP is ignored.
REQ-036 Scenario: mask=0. Required: ap_ready, then ap_done within 4 cycles and run_count increments.
REQ-037 Scenario: areset for 1 cycle during BUSY. Required: outputs return to the REQ-027 values and run_count=0.
REQ-038 Scenario: macro on, WDOG_W=4, no cu_done. Required: timeout=1 and ap_done after 15 BUSY cycles, run_count unchanged.

Source files
------------

// File: rtl/kernel_control_multi_cu_pkg.sv
// Shared definitions for the multi-CU kernel controller: state encoding and parameter defaults.
// The optional watchdog is enabled with KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN.
package PKG_CONTROL;

  localparam int NUM_CHANNELS_DEF = 4;
  localparam int RUN_COUNT_W_DEF  = 32;
  localparam int WDOG_W_DEF       = 24;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_READY = 3'd3,
    ST_START = 3'd4,
    ST_BUSY  = 3'd5,
    ST_DONE  = 3'd6
  } control_sync_state_multi_cu;

endpackage

// File: rtl/kernel_control_multi_cu_if.sv
// Host/channel handshake bundle for kernel_control_multi_cu.
// The timeout flag exists only with KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN.
interface kernel_control_multi_cu_if #(
  parameter int NUM_CHANNELS = PKG_CONTROL::NUM_CHANNELS_DEF,
  parameter int RUN_COUNT_W  = PKG_CONTROL::RUN_COUNT_W_DEF
);

  logic                    ap_start;
  logic [NUM_CHANNELS-1:0] channel_enable;
  logic [NUM_CHANNELS-1:0] cu_setup;
  logic [NUM_CHANNELS-1:0] cu_done;
  logic                    endian_cfg;

  logic                    ap_ready;
  logic                    ap_done;
  logic                    ap_idle;
  logic [NUM_CHANNELS-1:0] cu_start;
  logic                    endian;
  logic                    descriptor_valid;
  logic [RUN_COUNT_W-1:0]  run_count;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
  logic                    timeout;
`endif

  modport master (
    output ap_start, channel_enable, cu_setup, cu_done, endian_cfg,
    input  ap_ready, ap_done, ap_idle, cu_start, endian, descriptor_valid, run_count
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
    , input timeout
`endif
  );

  modport slave (
    input  ap_start, channel_enable, cu_setup, cu_done, endian_cfg,
    output ap_ready, ap_done, ap_idle, cu_start, endian, descriptor_valid, run_count
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/kernel_control_multi_cu_done_tracker.sv
// Per-channel sticky done bits; all_done also counts a done arriving in the current capture cycle.
// Unaffected by KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN.
module kernel_control_done_tracker #(
  parameter int NUM_CHANNELS = PKG_CONTROL::NUM_CHANNELS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    capture,
  input  logic [NUM_CHANNELS-1:0] cu_done,
  input  logic [NUM_CHANNELS-1:0] mask,
  output logic                    all_done
);

  logic [NUM_CHANNELS-1:0] sticky_q;
  logic [NUM_CHANNELS-1:0] sticky_d;
  logic [NUM_CHANNELS-1:0] seen;

  always_comb begin
    sticky_d = sticky_q;
    seen     = sticky_q;
    if (clear) begin
      sticky_d = '0;
    end else if (capture) begin
      sticky_d = sticky_q | cu_done;
      seen     = sticky_q | cu_done;
    end
    // Disabled channels count as finished, so an empty mask completes at once.
    all_done = &(seen | ~mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: rtl/kernel_control_multi_cu.sv
// Kernel controller sequencing a host start across several compute-unit channels.
// Define KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN to add the BUSY watchdog and timeout flag.
module kernel_control_multi_cu
  import PKG_CONTROL::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int RUN_COUNT_W  = RUN_COUNT_W_DEF,
  parameter int WDOG_W       = WDOG_W_DEF
) (
  input logic                      ap_clk,
  input logic                      areset,
  kernel_control_multi_cu_if.slave bus
);

  localparam logic [RUN_COUNT_W-1:0] RUN_ONE = RUN_COUNT_W'(1);

  control_sync_state_multi_cu state_q, state_d;

  logic                    ap_start_q, ap_start_d;
  logic [NUM_CHANNELS-1:0] channel_enable_q, channel_enable_d;
  logic [NUM_CHANNELS-1:0] cu_setup_q, cu_setup_d;
  logic [NUM_CHANNELS-1:0] cu_done_q, cu_done_d;
  logic                    endian_cfg_q, endian_cfg_d;

  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    endian_lat_q, endian_lat_d;
  logic [RUN_COUNT_W-1:0]  run_count_q, run_count_d;

  logic                    ap_ready_q, ap_ready_d;
  logic                    ap_done_q, ap_done_d;
  logic                    ap_idle_q, ap_idle_d;
  logic [NUM_CHANNELS-1:0] cu_start_q, cu_start_d;
  logic                    endian_q, endian_d;
  logic                    descriptor_valid_q, descriptor_valid_d;

  logic                    trk_clear;
  logic                    trk_capture;
  logic                    all_done;
  logic                    setup_ok;

`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              timeout_q, timeout_d;
`else
  logic [31:0]       unused_wdog_w;
  assign unused_wdog_w = WDOG_W;
`endif

  always_comb begin
    ap_start_d       = bus.ap_start;
    channel_enable_d = bus.channel_enable;
    cu_setup_d       = bus.cu_setup;
    cu_done_d        = bus.cu_done;
    endian_cfg_d     = bus.endian_cfg;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_q       <= 1'b0;
      channel_enable_q <= '0;
      cu_setup_q       <= '0;
      cu_done_q        <= '0;
      endian_cfg_q     <= 1'b0;
    end else begin
      ap_start_q       <= ap_start_d;
      channel_enable_q <= channel_enable_d;
      cu_setup_q       <= cu_setup_d;
      cu_done_q        <= cu_done_d;
      endian_cfg_q     <= endian_cfg_d;
    end
  end

  kernel_control_done_tracker #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_done_tracker (
    .clk      (ap_clk),
    .rst      (areset),
    .clear    (trk_clear),
    .capture  (trk_capture),
    .cu_done  (cu_done_q),
    .mask     (mask_q),
    .all_done (all_done)
  );

  assign setup_ok = &(cu_setup_q | ~mask_q);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    endian_lat_d = endian_lat_q;
    run_count_d  = run_count_q;
    trk_clear    = 1'b0;
    trk_capture  = 1'b0;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
    wdog_d       = wdog_q;
    wdog_inc     = wdog_q + WDOG_ONE;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  state_d = ST_SETUP;
      ST_SETUP: begin
        if (ap_start_q) begin
          state_d = ST_READY;
          mask_d  = channel_enable_q;
        end
      end
      ST_READY: begin
        if (setup_ok) begin
          state_d   = ST_START;
          trk_clear = 1'b1;
        end
      end
      ST_START: begin
        state_d      = ST_BUSY;
        endian_lat_d = endian_cfg_q;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
        wdog_d       = '0;
`endif
      end
      ST_BUSY: begin
        trk_capture = 1'b1;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
        wdog_d      = wdog_inc;
`endif
        if (all_done) begin
          state_d     = ST_DONE;
          run_count_d = run_count_q + RUN_ONE;
        end
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
        // A genuine completion in the final watchdog cycle still counts as a run.
        else if (wdog_inc == '1) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (ap_start_q) begin
          state_d = ST_READY;
          mask_d  = channel_enable_q;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Handshake outputs are a registered decode of the current state.
  always_comb begin
    ap_ready_d         = 1'b0;
    ap_done_d          = 1'b0;
    ap_idle_d          = 1'b0;
    cu_start_d         = '0;
    endian_d           = 1'b0;
    descriptor_valid_d = 1'b0;
    case (state_q)
      ST_RESET, ST_IDLE: ap_idle_d = 1'b1;
      ST_SETUP: begin
        ap_idle_d  = 1'b1;
        cu_start_d = mask_q;
      end
      ST_READY: begin
        ap_ready_d = 1'b1;
        cu_start_d = mask_q;
      end
      ST_START: begin
        descriptor_valid_d = 1'b1;
        cu_start_d         = mask_q;
        endian_d           = endian_cfg_q;
      end
      ST_BUSY: begin
        descriptor_valid_d = 1'b1;
        cu_start_d         = mask_q;
        endian_d           = endian_lat_q;
      end
      ST_DONE: begin
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
      end
      default: ap_idle_d = 1'b1;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q            <= ST_RESET;
      mask_q             <= '0;
      endian_lat_q       <= 1'b0;
      run_count_q        <= '0;
      ap_ready_q         <= 1'b0;
      ap_done_q          <= 1'b0;
      ap_idle_q          <= 1'b1;
      cu_start_q         <= '0;
      endian_q           <= 1'b0;
      descriptor_valid_q <= 1'b0;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
      wdog_q             <= '0;
      timeout_q          <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      mask_q             <= mask_d;
      endian_lat_q       <= endian_lat_d;
      run_count_q        <= run_count_d;
      ap_ready_q         <= ap_ready_d;
      ap_done_q          <= ap_done_d;
      ap_idle_q          <= ap_idle_d;
      cu_start_q         <= cu_start_d;
      endian_q           <= endian_d;
      descriptor_valid_q <= descriptor_valid_d;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
      wdog_q             <= wdog_d;
      timeout_q          <= timeout_d;
`endif
    end
  end

  assign bus.ap_ready         = ap_ready_q;
  assign bus.ap_done          = ap_done_q;
  assign bus.ap_idle          = ap_idle_q;
  assign bus.cu_start         = cu_start_q;
  assign bus.endian           = endian_q;
  assign bus.descriptor_valid = descriptor_valid_q;
  assign bus.run_count        = run_count_q;
`ifdef KERNEL_CONTROL_MULTI_CU_WATCHDOG_EN
  assign bus.timeout          = timeout_q;
`endif

endmodule
